// File: rtl/ddr_cmd_queue.sv
// Host request FIFO and command issuer in front of the DDR SDRAM driver.
// Optional statistics counters are enabled with `define DDR_CMD_QUEUE_STATS_EN.
module ddr_cmd_queue #(
  parameter int DEPTH         = 8,
  parameter int ISSUE_TIMEOUT = 64
) (
  input  logic                     SYS_CLK_100M,
  input  logic                     RESET_N,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WRITE,
  input  logic [1:0]               REQ_BA,
  input  logic [12:0]              REQ_ROW,
  input  logic [9:0]               REQ_COL,
  input  logic [3:0]               REQ_LEN,
  output logic                     WRITE,
  output logic                     READ,
  output logic [1:0]               BA_IN,
  output logic [12:0]              ADDR_ROW_IN,
  output logic [9:0]               ADDR_COL_IN,
  output logic [3:0]               WRITE_LENGTH,
  input  logic                     BUSY,
  output logic [$clog2(DEPTH):0]   Q_COUNT,
  output logic                     Q_EMPTY,
  output logic                     ISSUE_ERR
`ifdef DDR_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]              STAT_RD,
  output logic [15:0]              STAT_WR,
  output logic [7:0]               STAT_TO
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ISSUE_TIMEOUT) + 1;
  localparam int EW = 30;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ISSUE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_busy_meta;
  logic            r_busy_s;
  logic [TW-1:0]   r_to_cnt;
  logic            r_write;
  logic            r_read;
  logic [1:0]      r_ba;
  logic [12:0]     r_row;
  logic [9:0]      r_col;
  logic [3:0]      r_len;
  logic            r_issue_err;
  logic            w_push;
  logic            w_pop;
  logic            w_started;
  logic            w_timeout;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;

  assign REQ_READY    = (r_count != FULL_CNT);
  assign Q_EMPTY      = (r_count == CNT_ZERO);
  assign Q_COUNT      = r_count;
  assign WRITE        = r_write;
  assign READ         = r_read;
  assign BA_IN        = r_ba;
  assign ADDR_ROW_IN  = r_row;
  assign ADDR_COL_IN  = r_col;
  assign WRITE_LENGTH = r_len;
  assign ISSUE_ERR    = r_issue_err;

  assign w_push      = REQ_VALID && REQ_READY;
  assign w_push_data = {REQ_WRITE, REQ_BA, REQ_ROW, REQ_COL, REQ_LEN};
  assign w_head      = r_mem[r_rptr];

  // BUSY comes from the driver's clock domain
  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= BUSY;
      r_busy_s    <= r_busy_meta;
    end
  end

  // FIFO storage
  always_ff @(posedge SYS_CLK_100M) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM state register
  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Issue FSM next state and handshake events
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_started   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Q_EMPTY && !r_busy_s) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_busy_s) begin
          w_started   = 1'b1;
          w_state_nxt = S_WAIT_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (!r_busy_s) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_WAIT_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Driver-facing command registers; address fields only reload on a pop
  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_ba        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_len       <= '0;
      r_to_cnt    <= '0;
      r_issue_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_write  <= w_head[29];
        r_read   <= !w_head[29];
        r_ba     <= w_head[28:27];
        r_row    <= w_head[26:14];
        r_col    <= w_head[13:4];
        r_len    <= w_head[3:0];
        r_to_cnt <= '0;
      end else if (w_started || w_timeout) begin
        r_write <= 1'b0;
        r_read  <= 1'b0;
      end else if (r_state == S_ISSUE) begin
        r_to_cnt <= r_to_cnt + TO_ONE;
      end
      if (w_timeout) r_issue_err <= 1'b1;
    end
  end

`ifdef DDR_CMD_QUEUE_STATS_EN
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_wr;
  logic [7:0]  r_stat_to;

  // Saturating issue / timeout statistics
  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stat_rd <= 16'd0;
      r_stat_wr <= 16'd0;
      r_stat_to <= 8'd0;
    end else begin
      if (w_started && r_read && (r_stat_rd != 16'hFFFF))  r_stat_rd <= r_stat_rd + 16'd1;
      if (w_started && r_write && (r_stat_wr != 16'hFFFF)) r_stat_wr <= r_stat_wr + 16'd1;
      if (w_timeout && (r_stat_to != 8'hFF))               r_stat_to <= r_stat_to + 8'd1;
    end
  end

  assign STAT_RD = r_stat_rd;
  assign STAT_WR = r_stat_wr;
  assign STAT_TO = r_stat_to;
`else
  // statistics counters not built
`endif

endmodule
